// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit: funct3 operation codes and FSM states.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide: fixed 33-cycle latency from accept to done, start ignored while busy.
// Mul and div share the operand registers, the 64-bit accumulator and the iteration counter.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic [4:0]  rdIn,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rdOut
);

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic [2:0]  op_q;
  logic [4:0]  rd_q;
  logic [31:0] opb_q;
  logic [63:0] acc;
  logic        neg_main;
  logic        neg_rem;

  logic        sign_a;
  logic        sign_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [63:0] div_next;
  logic [63:0] prod;
  logic [31:0] quot;
  logic [31:0] remv;
  logic [31:0] final_val;

  // Operand sign treatment at accept time; magnitudes are what the iterations work on.
  always_comb begin
    sign_a = operandA[31] & (funct3 == OP_MUL || funct3 == OP_MULH || funct3 == OP_MULHSU ||
                             funct3 == OP_DIV || funct3 == OP_REM);
    sign_b = operandB[31] & (funct3 == OP_MUL || funct3 == OP_MULH ||
                             funct3 == OP_DIV || funct3 == OP_REM);
    mag_a  = sign_a ? -operandA : operandA;
    mag_b  = sign_b ? -operandB : operandB;
  end

  // Multiply: acc = {partial, multiplier}, shifted right each step.
  // Divide: acc = {remainder, dividend/quotient}, shifted left each step.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb_q} : 33'd0);
    mul_next = {mul_sum, acc[31:1]};
    rem_sh   = acc[63:31];
    diff     = rem_sh - {1'b0, opb_q};
    div_next = diff[32] ? {rem_sh[31:0], acc[30:0], 1'b0}
                        : {diff[31:0],   acc[30:0], 1'b1};
  end

  always_comb begin
    prod = neg_main ? -acc : acc;
    quot = neg_main ? -acc[31:0] : acc[31:0];
    remv = neg_rem ? -acc[63:32] : acc[63:32];
    case (op_q)
      OP_MUL:                       final_val = prod[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_val = prod[63:32];
      OP_DIV, OP_DIVU:              final_val = (opb_q == 32'd0) ? 32'hFFFF_FFFF : quot;
      default:                      final_val = remv;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= 6'd0;
      op_q     <= 3'd0;
      rd_q     <= 5'd0;
      opb_q    <= 32'd0;
      acc      <= 64'd0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      result   <= 32'd0;
      rdOut    <= 5'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_CALC;
            cnt      <= 6'd0;
            op_q     <= funct3;
            rd_q     <= rdIn;
            opb_q    <= mag_b;
            acc      <= {32'd0, mag_a};
            neg_main <= sign_a ^ sign_b;
            neg_rem  <= sign_a;
          end
        end
        S_CALC: begin
          // 32 iteration edges, then one edge to apply sign and special cases.
          if (cnt == 6'd32) begin
            state  <= S_DONE;
            cnt    <= 6'd0;
            result <= final_val;
            rdOut  <= rd_q;
          end else begin
            cnt <= cnt + 6'd1;
            acc <= op_q[2] ? div_next : mul_next;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit with hand-computed results and latency checks.
module tb_muldiv_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic [4:0]  rdIn;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rdOut;

  int n_vec;
  int n_bad;

  muldiv_unit dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .funct3   (funct3),
    .operandA (operandA),
    .operandB (operandB),
    .rdIn     (rdIn),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .rdOut    (rdOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one op, scramble inputs after accept, check busy/done timing and the result.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int early;
    early = 0;
    @(negedge clock);
    funct3 = f3; operandA = a; operandB = b; rdIn = rd; start = 1'b1;
    @(negedge clock);  // after accepting edge N
    start = 1'b0;
    funct3 = ~f3; operandA = $urandom; operandB = $urandom; rdIn = ~rd;
    if (done || !busy) early++;
    repeat (32) begin
      @(negedge clock);  // after edges N+1 .. N+32
      if (done || !busy) early++;
    end
    check({tag, "_timing"}, early, 0);
    @(negedge clock);  // after edge N+33
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_result"}, result, exp);
    check({tag, "_rd"}, {27'd0, rdOut}, {27'd0, rd});
    @(negedge clock);  // after edge N+34
    check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    reset = 1'b1; start = 1'b1;
    funct3 = 3'b000; operandA = 32'd1; operandB = 32'd1; rdIn = 5'd3;
    repeat (2) @(negedge clock);
    // Reset state, with start held high alongside reset
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd", {27'd0, rdOut}, 32'd0);
    reset = 1'b0; start = 1'b0;
    @(negedge clock);
    check("rst_start_ignored", {31'd0, busy}, 32'd0);

    run_op("mul_neg",   3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB);
    run_op("mulh_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000);
    run_op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE);
    run_op("mulhsu",    3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF);
    run_op("div_neg",   3'b100, 32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD);
    run_op("rem_neg",   3'b110, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF);
    run_op("divu",      3'b101, 32'd100,       32'd7,         5'd7,  32'd14);
    run_op("remu",      3'b111, 32'd100,       32'd7,         5'd0,  32'd2);
    run_op("div_by0",   3'b100, 32'd5,         32'd0,         5'd8,  32'hFFFF_FFFF);
    run_op("divn_by0",  3'b100, 32'hFFFF_FFFB, 32'd0,         5'd9,  32'hFFFF_FFFF);
    run_op("remu_by0",  3'b111, 32'd5,         32'd0,         5'd10, 32'd5);
    run_op("rem_by0",   3'b110, 32'hFFFF_FFF9, 32'd0,         5'd11, 32'hFFFF_FFF9);
    run_op("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000);
    run_op("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0);
    run_op("mul_big",   3'b000, 32'h1234_5678, 32'h0000_0010, 5'd31, 32'h2345_6780);
    run_op("mulhu_mix", 3'b011, 32'h8000_0000, 32'h0000_0004, 5'd14, 32'd2);

    // Second start during CALC must be ignored
    @(negedge clock);
    funct3 = 3'b000; operandA = 32'd7; operandB = 32'hFFFF_FFFD; rdIn = 5'd5; start = 1'b1;
    @(negedge clock);  // after edge N
    start = 1'b0;
    repeat (4) @(negedge clock);
    funct3 = 3'b101; operandA = 32'd99; operandB = 32'd3; rdIn = 5'd20; start = 1'b1;
    @(negedge clock);  // after edge N+5
    start = 1'b0;
    begin
      int waited;
      waited = 0;
      while (!done && waited < 60) begin
        @(negedge clock);
        waited++;
      end
      check("restart_latency", waited, 28);
    end
    check("restart_result", result, 32'hFFFF_FFEB);
    check("restart_rd", {27'd0, rdOut}, 32'd5);
    @(negedge clock);
    @(negedge clock);
    check("restart_idle", {31'd0, busy}, 32'd0);

    // Reset mid-operation aborts without a done pulse
    funct3 = 3'b100; operandA = 32'd100; operandB = 32'd7; rdIn = 5'd9; start = 1'b1;
    @(negedge clock);  // after edge N
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);  // after edge N+10
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_rd", {27'd0, rdOut}, 32'd0);
    begin
      int seen;
      seen = 0;
      repeat (40) begin
        @(negedge clock);
        if (done || busy) seen++;
      end
      check("abort_no_done", seen, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
